// File: rtl/nn_pkg.sv
// Shared constants and types for the network's output-side blocks.
package nn_pkg;

  localparam int WIDTH_DEF = 10;
  localparam int NFRAC_DEF = 5;
  localparam int SIZE_DEF  = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } stream_state_t;

  // Index width that stays at least one bit wide for single-element vectors.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/argmax_tracker.sv
// Running signed maximum with lowest-index tie-break; latches the result on done.
module argmax_tracker
  import nn_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDXW  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init,
  input  logic signed [WIDTH-1:0] init_value,
  input  logic                    update,
  input  logic signed [WIDTH-1:0] upd_value,
  input  logic [IDXW-1:0]         upd_index,
  input  logic                    done,
  output logic                    res_valid,
  output logic [IDXW-1:0]         res_index,
  output logic signed [WIDTH-1:0] res_value
);

  logic signed [WIDTH-1:0] max_q, max_d;
  logic [IDXW-1:0]         maxidx_q, maxidx_d;
  logic                    res_valid_q, res_valid_d;
  logic [IDXW-1:0]         res_index_q, res_index_d;
  logic signed [WIDTH-1:0] res_value_q, res_value_d;

  always_comb begin
    max_d       = max_q;
    maxidx_d    = maxidx_q;
    if (init) begin
      max_d    = init_value;
      maxidx_d = '0;
    end else if (update && (upd_value > max_q)) begin
      max_d    = upd_value;
      maxidx_d = upd_index;
    end
    // The final element is folded in on the same beat that completes the vector.
    res_valid_d = done;
    res_index_d = done ? maxidx_d : res_index_q;
    res_value_d = done ? max_d : res_value_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q       <= '0;
      maxidx_q    <= '0;
      res_valid_q <= 1'b0;
      res_index_q <= '0;
      res_value_q <= '0;
    end else begin
      max_q       <= max_d;
      maxidx_q    <= maxidx_d;
      res_valid_q <= res_valid_d;
      res_index_q <= res_index_d;
      res_value_q <= res_value_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_index = res_index_q;
  assign res_value = res_value_q;

endmodule

// File: rtl/layer_output_streamer.sv
// Captures a full activation vector and replays it one element per beat,
// reporting the argmax (class decision) once the last beat is accepted.
module layer_output_streamer
  import nn_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NFRAC = NFRAC_DEF,
  parameter int SIZE  = SIZE_DEF,
  parameter int IDXW  = idx_width(SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] input_data [SIZE-1:0],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic [IDXW-1:0]         out_index,
  output logic                    out_last,
  output logic                    argmax_valid,
  output logic [IDXW-1:0]         argmax_index,
  output logic signed [WIDTH-1:0] argmax_value
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SIZE - 1);

  generate
    if (SIZE < 1 || NFRAC < 0 || NFRAC >= WIDTH) begin : g_bad_cfg
      $error("layer_output_streamer: invalid SIZE/NFRAC/WIDTH combination");
    end
  endgenerate

  stream_state_t           state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic signed [WIDTH-1:0] buf_q [SIZE-1:0];
  logic signed [WIDTH-1:0] buf_d [SIZE-1:0];
  logic signed [WIDTH-1:0] cur_elem;
  logic                    capture, fire, at_last;

  generate
    if (SIZE == 1) begin : g_one
      assign cur_elem = buf_q[0];
    end else begin : g_many
      assign cur_elem = buf_q[idx_q];
    end
  endgenerate

  assign capture = (state_q == IDLE) && in_valid;
  assign fire    = (state_q == SEND) && out_ready;
  assign at_last = (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SEND;
          idx_d   = '0;
          buf_d   = input_data;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (at_last) state_d = IDLE;
          else         idx_d   = idx_q + IDXW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Vector storage carries no reset; it is only read while streaming.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  argmax_tracker #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_argmax (
    .clk        (clk),
    .rst        (rst),
    .init       (capture),
    .init_value (input_data[0]),
    .update     (fire && (idx_q != '0)),
    .upd_value  (cur_elem),
    .upd_index  (idx_q),
    .done       (fire && at_last),
    .res_valid  (argmax_valid),
    .res_index  (argmax_index),
    .res_value  (argmax_value)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == SEND);
  assign out_data  = out_valid ? cur_elem : '0;
  assign out_index = out_valid ? idx_q : '0;
  assign out_last  = out_valid && at_last;

endmodule
